// File: rtl/hamming_encoder_stream_if.sv
// Valid/ready stream bundle for the (21,16) Hamming encoder; data and codeword use [0:N] bit order.
// Injection signals exist only when HAMMING_ERR_INJECT_EN is defined.
interface hamming_encoder_stream_if;
    // Handshake: a word moves when valid && ready at a rising edge; a producer holds valid/data until then.
    logic        in_valid;
    logic        in_ready;
    logic [0:15] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [0:20] out_code;
`ifdef HAMMING_ERR_INJECT_EN
    logic        inj_en;
    logic [4:0]  inj_pos;
`endif

    modport slave (
`ifdef HAMMING_ERR_INJECT_EN
        input  inj_en,
        input  inj_pos,
`endif
        input  in_valid,
        output in_ready,
        input  in_data,
        output out_valid,
        input  out_ready,
        output out_code
    );

    modport master (
`ifdef HAMMING_ERR_INJECT_EN
        output inj_en,
        output inj_pos,
`endif
        output in_valid,
        input  in_ready,
        output in_data,
        input  out_valid,
        output out_ready,
        input  out_code
    );
endinterface

// File: rtl/hamming_encoder_stream.sv
// Streaming (21,16) even-parity Hamming encoder with a two-stage elastic pipeline and codeword counter.
// Optional single-bit error injection is enabled by defining HAMMING_ERR_INJECT_EN.
module hamming_encoder_stream #(
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    hamming_encoder_stream_if.slave bus,
    output logic [CNT_W-1:0]     cw_count
);

    function automatic logic [0:20] encode(input logic [0:15] d);
        logic [0:20] c;
        c = '0;
        c[2]  = d[0];
        c[4]  = d[1];
        c[5]  = d[2];
        c[6]  = d[3];
        c[8:14]  = d[4:10];
        c[16:20] = d[11:15];
        c[0]  = c[2] ^ c[4] ^ c[6] ^ c[8] ^ c[10] ^ c[12] ^ c[14] ^ c[16] ^ c[18] ^ c[20];
        c[1]  = c[2] ^ c[5] ^ c[6] ^ c[9] ^ c[10] ^ c[13] ^ c[14] ^ c[17] ^ c[18];
        c[3]  = c[4] ^ c[5] ^ c[6] ^ c[11] ^ c[12] ^ c[13] ^ c[14] ^ c[19] ^ c[20];
        c[7]  = ^c[8:14];
        c[15] = ^c[16:20];
        return c;
    endfunction

    logic        s1_valid;
    logic [0:15] s1_data;
    logic        out_valid_q;
    logic [0:20] out_code_q;
    logic [0:20] s2_code;
    logic        in_xfer;
    logic        out_xfer;
    logic        s2_load;

`ifdef HAMMING_ERR_INJECT_EN
    logic        s1_inj_en;
    logic [4:0]  s1_inj_pos;
`endif

    assign bus.in_ready  = !s1_valid || !out_valid_q || bus.out_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_code  = out_code_q;

    assign in_xfer  = bus.in_valid && bus.in_ready;
    assign out_xfer = out_valid_q && bus.out_ready;
    assign s2_load  = s1_valid && (!out_valid_q || bus.out_ready);

    // Injection flips a bit after parity so the decoder sees a genuine single-bit error.
    always_comb begin
        s2_code = encode(s1_data);
`ifdef HAMMING_ERR_INJECT_EN
        if (s1_inj_en && (s1_inj_pos <= 5'd20)) begin
            s2_code[s1_inj_pos] = !s2_code[s1_inj_pos];
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid    <= 1'b0;
            s1_data     <= '0;
            out_valid_q <= 1'b0;
            out_code_q  <= '0;
            cw_count    <= '0;
`ifdef HAMMING_ERR_INJECT_EN
            s1_inj_en   <= 1'b0;
            s1_inj_pos  <= '0;
`endif
        end else begin
            if (in_xfer) begin
                s1_valid <= 1'b1;
                s1_data  <= bus.in_data;
`ifdef HAMMING_ERR_INJECT_EN
                s1_inj_en  <= bus.inj_en;
                s1_inj_pos <= bus.inj_pos;
`endif
            end else if (s2_load) begin
                s1_valid <= 1'b0;
            end

            if (s2_load) begin
                out_valid_q <= 1'b1;
                out_code_q  <= s2_code;
            end else if (out_xfer) begin
                out_valid_q <= 1'b0;
            end

            if (out_xfer) begin
                cw_count <= cw_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_hamming_encoder_stream.sv
// Bench for hamming_encoder_stream: vector table, random backpressured stream, stall/reset and counter wrap.
// Codewords are predicted by a positional Hamming model and checked in order through an expected queue.
module tb_hamming_encoder_stream;

    localparam int CNT_W = 4;

    logic             clk;
    logic             rst;
    logic [CNT_W-1:0] cw_count;

    hamming_encoder_stream_if bus();

    hamming_encoder_stream #(.CNT_W(CNT_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .cw_count (cw_count)
    );

    initial clk = 1'b0;
    always #5 clk = !clk;

    typedef struct {
        logic [0:15] data;
        logic [0:20] code;
    } vec_t;

    logic [20:0]      exp_q[$];
    logic [CNT_W-1:0] exp_cnt;
    int               checks;
    int               errors;
    logic             obs_acc;
    logic             obs_valid;
    logic [0:20]      obs_code;
    logic             cur_inj_en;
    logic [4:0]       cur_inj_pos;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Hamming positions 1..21: powers of two hold parity over every position sharing that bit.
    function automatic logic [0:20] ref_encode(input logic [0:15] d);
        logic [0:20] c;
        int k;
        logic par;
        c = '0;
        k = 0;
        for (int p = 1; p <= 21; p++) begin
            if ((p & (p - 1)) != 0) begin
                c[p-1] = d[k];
                k++;
            end
        end
        for (int b = 0; b < 5; b++) begin
            par = 1'b0;
            for (int p = 1; p <= 21; p++) begin
                if (((p >> b) & 1) == 1 && p != (1 << b)) par = par ^ c[p-1];
            end
            c[(1 << b) - 1] = par;
        end
        return c;
    endfunction

    task automatic cycle(input logic iv, input logic [0:15] d, input logic [0:20] exp, input logic ordy);
        logic exp_rdy;
        @(negedge clk);
        bus.in_valid  = iv;
        bus.in_data   = d;
        bus.out_ready = ordy;
`ifdef HAMMING_ERR_INJECT_EN
        bus.inj_en    = cur_inj_en;
        bus.inj_pos   = cur_inj_pos;
`endif
        #1;
        exp_rdy = !(exp_q.size() == 2 && !ordy);
        check("in_ready", {31'd0, bus.in_ready}, {31'd0, exp_rdy});
        check("cw_count", {{(32-CNT_W){1'b0}}, cw_count}, {{(32-CNT_W){1'b0}}, exp_cnt});
        obs_acc   = iv && bus.in_ready;
        obs_valid = bus.out_valid;
        obs_code  = bus.out_code;
        if (bus.out_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_out: got out_valid=1 code %h expected no word at %0t", bus.out_code, $time);
            end else begin
                check("out_code", {11'd0, bus.out_code}, {11'd0, exp_q[0]});
                if (ordy) begin
                    void'(exp_q.pop_front());
                    exp_cnt++;
                end
            end
        end
        if (obs_acc) exp_q.push_back(exp);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst           = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_data   = 16'hA5A5;
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        exp_q.delete();
        exp_cnt = '0;
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) cycle(1'b0, 16'h0, 21'h0, 1'b1);
        check("drain_empty", exp_q.size(), 0);
    endtask

    initial begin
        vec_t        vecs[5];
        logic [0:15] w;
        logic [0:20] hold_code;
        int          sent;
        int          acc;

        checks = 0;
        errors = 0;
        exp_cnt = '0;
        cur_inj_en = 1'b0;
        cur_inj_pos = '0;
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data = '0;
        bus.out_ready = 1'b0;
`ifdef HAMMING_ERR_INJECT_EN
        bus.inj_en = 1'b0;
        bus.inj_pos = '0;
`endif

        vecs[0] = '{16'h0000, 21'h000000};
        vecs[1] = '{16'hFFFF, 21'h0FFFFF};
        vecs[2] = '{16'h8000, 21'h1C0000};
        vecs[3] = '{16'h0001, 21'h120021};
        vecs[4] = '{16'h4000, 21'h130000};

        do_reset();
        #1;
        check("rst_out_valid", {31'd0, bus.out_valid}, 0);
        check("rst_out_code", {11'd0, bus.out_code}, 0);
        check("rst_cw_count", {{(32-CNT_W){1'b0}}, cw_count}, 0);
        check("rst_in_ready", {31'd0, bus.in_ready}, 1);

        // Latency: empty after the accept edge, valid one edge later.
        cycle(1'b1, 16'h0000, 21'h000000, 1'b1);
        cycle(1'b0, 16'h0, 21'h0, 1'b1);
        check("lat_first", {31'd0, obs_valid}, 0);
        cycle(1'b0, 16'h0, 21'h0, 1'b1);
        check("lat_second", {31'd0, obs_valid}, 1);
        drain();

        for (int i = 0; i < 5; i++) cycle(1'b1, vecs[i].data, vecs[i].code, 1'b1);
        drain();

        sent = 0;
        w = 16'($urandom);
        for (int i = 0; i < 200 && sent < 20; i++) begin
            logic iv;
            iv = ($urandom_range(0, 3) != 0);
            cycle(iv, w, ref_encode(w), 1'($urandom_range(0, 1)));
            if (obs_acc) begin
                sent++;
                w = 16'($urandom);
            end
        end
        check("stream_sent", sent, 20);
        drain();

        acc = 0;
        for (int i = 0; i < 6; i++) begin
            w = 16'($urandom);
            cycle(1'b1, w, ref_encode(w), 1'b0);
            if (obs_acc) acc++;
            if (i == 2) hold_code = obs_code;
            if (i > 2) check("stall_stable", {11'd0, obs_code}, {11'd0, hold_code});
        end
        check("stall_accepted", acc, 2);

        @(negedge clk);
        rst = 1'b1;
        bus.in_valid = 1'b1;
        bus.out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        check("midrst_out_valid", {31'd0, bus.out_valid}, 0);
        check("midrst_cw_count", {{(32-CNT_W){1'b0}}, cw_count}, 0);
        exp_q.delete();
        exp_cnt = '0;
        for (int i = 0; i < 5; i++) cycle(1'b0, 16'h0, 21'h0, 1'b1);

`ifdef HAMMING_ERR_INJECT_EN
        cur_inj_en = 1'b1;
        cur_inj_pos = 5'd7;
        cycle(1'b1, 16'h0000, 21'h002000, 1'b1);
        cur_inj_pos = 5'd20;
        cycle(1'b1, 16'h0000, 21'h000001, 1'b1);
        cur_inj_pos = 5'd25;
        cycle(1'b1, 16'h0000, 21'h000000, 1'b1);
        cur_inj_en = 1'b0;
        cur_inj_pos = 5'd7;
        cycle(1'b1, 16'hFFFF, 21'h0FFFFF, 1'b1);
        drain();
`endif

        do_reset();
        for (int i = 0; i < 17; i++) begin
            w = 16'($urandom);
            cycle(1'b1, w, ref_encode(w), 1'b1);
        end
        drain();
        @(negedge clk);
        #1;
        check("wrap_cw_count", {{(32-CNT_W){1'b0}}, cw_count}, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
